// File: rtl/ws2812b_tx.sv
// WS2812B single-wire serializer: 24-bit GRB words over valid/ready, MSB first,
// with automatic latch (reset) low period inserted whenever the stream starves.
module ws2812b_tx #(
  parameter int T_BIT   = 15,
  parameter int T0H     = 5,
  parameter int T1H     = 10,
  parameter int T_RESET = 960
) (
  input  logic        clk_12mhz,
  input  logic        resetn,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        dout,
  output logic        busy,
  output logic        latch_done
);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
    $error("ws2812b_tx: require 0 < T0H < T1H < T_BIT");
  end
  if (T_RESET < 1 || T_RESET > 65535) begin : g_bad_reset
    $error("ws2812b_tx: T_RESET must be in 1..65535");
  end

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [15:0]   LAT_LAST = 16'(T_RESET - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cyc, cyc_nx;
  logic [4:0]    bit_idx, bit_idx_nx;
  logic [23:0]   shreg, shreg_nx;
  logic [15:0]   lcnt, lcnt_nx;
  logic          done_nx;
  logic          dout_nx;
  logic          accept;

  // Ready only in IDLE or on the very last cycle of bit 0, so a waiting word
  // slots in with no gap between pixels.
  assign pixel_ready = (state == IDLE) ||
                       (state == SEND && bit_idx == 5'd0 && cyc == CYC_LAST);
  assign accept      = pixel_valid && pixel_ready;

  always_comb begin
    state_nx   = state;
    cyc_nx     = cyc;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    lcnt_nx    = lcnt;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx   = SEND;
          shreg_nx   = pixel_data;
          bit_idx_nx = 5'd23;
          cyc_nx     = '0;
        end
      end
      SEND: begin
        if (cyc == CYC_LAST) begin
          cyc_nx = '0;
          if (bit_idx != 5'd0) begin
            bit_idx_nx = bit_idx - 5'd1;
            shreg_nx   = {shreg[22:0], 1'b0};
          end else if (accept) begin
            shreg_nx   = pixel_data;
            bit_idx_nx = 5'd23;
          end else begin
            state_nx = LATCH;
            lcnt_nx  = '0;
          end
        end else begin
          cyc_nx = cyc + 1'b1;
        end
      end
      LATCH: begin
        if (lcnt == LAT_LAST) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          lcnt_nx = lcnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // dout is registered from the next state so it rises on the accept edge.
    dout_nx = (state_nx == SEND) && (cyc_nx < (shreg_nx[23] ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk_12mhz or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cyc        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      lcnt       <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      latch_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cyc        <= cyc_nx;
      bit_idx    <= bit_idx_nx;
      shreg      <= shreg_nx;
      lcnt       <= lcnt_nx;
      dout       <= dout_nx;
      busy       <= (state_nx != IDLE);
      latch_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_ws2812b_tx.sv
// Scoreboard bench for ws2812b_tx: accepted words push their ideal waveform,
// a monitor pops one level per cycle and tracks the latch period.
module tb_ws2812b_tx;

  localparam int T_BIT = 15, T0H = 5, T1H = 10, T_RESET = 960;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready, dout, busy, latch_done;

  logic [23:0] data2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2, dout2, busy2, done2;

  int  tot = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  bit  pend = 1'b0;
  int  lat_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  ws2812b_tx #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)) dut (
    .clk_12mhz(clk), .resetn(resetn), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .dout(dout),
    .busy(busy), .latch_done(latch_done));

  ws2812b_tx #(.T_BIT(4), .T0H(1), .T1H(3), .T_RESET(2)) dut2 (
    .clk_12mhz(clk), .resetn(resetn), .pixel_data(data2),
    .pixel_valid(valid2), .pixel_ready(ready2), .dout(dout2),
    .busy(busy2), .latch_done(done2));

  task automatic chk(input string name, input logic act, input logic exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Ideal line level at cycle idx after the accept edge, straight from the bit rules.
  function automatic logic wave_level(input logic [23:0] px, input int idx,
                                      input int tb, input int t0, input int t1);
    int b, c;
    b = 23 - idx / tb;
    c = idx % tb;
    return (c < (px[b] ? t1 : t0));
  endfunction

  task automatic push_wave(input logic [23:0] px);
    for (int i = 0; i < 24 * T_BIT; i++) exp_q.push_back(wave_level(px, i, T_BIT, T0H, T1H));
  endtask

  // Monitor: one sample per cycle, 2 time units after the rising edge.
  initial begin
    logic e;
    forever begin
      @(posedge clk); #2;
      if (resetn && mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("dout_bit", dout, e);
          chk("busy_send", busy, 1'b1);
          chk("ready_send", pixel_ready, exp_q.size() == 0);
          chk("done_send", latch_done, 1'b0);
          pend = 1'b1;
          lat_cnt = 0;
        end else if (pend) begin
          lat_cnt++;
          if (lat_cnt <= T_RESET) begin
            chk("dout_latch", dout, 1'b0);
            chk("busy_latch", busy, 1'b1);
            chk("ready_latch", pixel_ready, 1'b0);
            chk("done_early", latch_done, 1'b0);
          end else begin
            chk("latch_done", latch_done, 1'b1);
            chk("busy_after", busy, 1'b0);
            chk("dout_after", dout, 1'b0);
            chk("ready_after", pixel_ready, 1'b1);
            pend = 1'b0;
          end
        end else begin
          chk("dout_idle", dout, 1'b0);
          chk("busy_idle", busy, 1'b0);
          chk("ready_idle", pixel_ready, 1'b1);
          chk("done_idle", latch_done, 1'b0);
        end
      end
    end
  end

  task automatic drive_cycle(input bit want, input logic [23:0] d, input bit noise,
                             output bit acc);
    @(negedge clk);
    acc = 1'b0;
    if (want) begin
      pixel_valid = 1'b1;
      pixel_data  = d;
      if (pixel_ready) begin
        push_wave(d);
        acc = 1'b1;
      end
    end else if (noise && !pixel_ready) begin
      pixel_valid = 1'($urandom_range(0, 1));
      pixel_data  = 24'($urandom);
    end else begin
      pixel_valid = 1'b0;
      pixel_data  = 24'($urandom);
    end
  endtask

  task automatic send_px(input logic [23:0] d);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 3000 && !acc; i++) drive_cycle(1'b1, d, 1'b0, acc);
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n, input bit noise);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 24'h0, noise, acc);
  endtask

  task automatic wait_idle();
    bit acc;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      drive_cycle(1'b0, 24'h0, 1'b0, acc);
      ok = !busy && exp_q.size() == 0 && !pend;
    end
    if (!ok) chk("idle_timeout", 1'b0, 1'b1);
    idle_cycles(3, 1'b0);
  endtask

  initial begin
    logic [23:0] w;
    #23;
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", latch_done, 1'b0);
    chk("rst_ready", pixel_ready, 1'b1);
    @(negedge clk); #3 resetn = 1'b1;
    mon_en = 1'b1;
    idle_cycles(4, 1'b0);

    // Single pixel, then starvation.
    send_px(24'hFF0000);
    wait_idle();

    // Two pixels back to back with valid held.
    send_px(24'hAAAAAA);
    send_px(24'h555555);
    wait_idle();

    // Valid raised while the latch period runs.
    send_px(24'h3C5A96);
    idle_cycles(370, 1'b0);
    send_px(24'hC3A569);
    wait_idle();

    // Random words with noisy valid/data while the block is busy.
    for (int k = 0; k < 4; k++) begin
      w = 24'($urandom);
      send_px(w);
      idle_cycles(200 + $urandom_range(0, 100), 1'b1);
      if (k % 2 == 0) send_px(24'($urandom));
      wait_idle();
    end

    // Asynchronous reset in the middle of bit 10 (line high).
    send_px(24'hFFFFFF);
    idle_cycles(198, 1'b0);
    chk("pre_reset_dout", dout, 1'b1);
    pixel_valid = 1'b0;
    #3 resetn = 1'b0;
    exp_q.delete();
    pend = 1'b0;
    #1;
    chk("async_dout", dout, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_ready", pixel_ready, 1'b1);
    chk("async_done", latch_done, 1'b0);
    @(negedge clk); #3 resetn = 1'b1;
    idle_cycles(3, 1'b0);
    send_px(24'h000000);
    wait_idle();

    // Scaled timing instance: T_BIT=4, T0H=1, T1H=3, T_RESET=2.
    mon_en = 1'b0;
    @(negedge clk);
    chk("p2_ready", ready2, 1'b1);
    valid2 = 1'b1;
    data2  = 24'h800001;
    @(posedge clk); #2;
    valid2 = 1'b0;
    data2  = 24'h7FFFFE;
    for (int k = 0; k < 100; k++) begin
      chk("p2_dout", dout2, (k < 96) ? wave_level(24'h800001, k, 4, 1, 3) : 1'b0);
      chk("p2_done", done2, k == 98);
      chk("p2_busy", busy2, k < 98);
      @(posedge clk); #2;
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
